// File: rtl/audio_pkg.sv
// rtl/audio_pkg.sv - shared register-select codes, sweep FSM states and saturation helper
package audio_pkg;

  typedef enum logic [3:0] {
    SET_IDLE            = 4'd0,
    SET_START           = 4'd1,
    SET_POSITION        = 4'd2,
    SET_SAMPLECOUNT     = 4'd3,
    SET_LOOPSTART       = 4'd4,
    SET_LOOPEND         = 4'd5,
    SET_ISLOOPING       = 4'd6,
    SET_ISPLAYING       = 4'd7,
    SET_VOLUME          = 4'd8,
    SET_LASTSAMPLE      = 4'd9,
    SET_ISSTEREO        = 4'd10,
    SET_ISLEFT          = 4'd11,
    SET_LOOPSTARTSAMPLE = 4'd12,
    SET_CLEAR_OVR       = 4'd15
  } channel_setting_e;

  typedef enum logic [2:0] {
    ST_IDLE, ST_SELECT, ST_REQ, ST_WAIT, ST_STEP, ST_NEXT, ST_DONE
  } state_e;

  // Clamp a sign-extended value into the signed range of a w-bit word.
  function automatic logic signed [31:0] sat(input logic signed [31:0] x, input int w);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (32'sd1 <<< (w - 1)) - 32'sd1;
    lo = -hi - 32'sd1;
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

endpackage

// File: rtl/audio_dpcm_step.sv
// rtl/audio_dpcm_step.sv - combinational DPCM step: delta expand, integrate, loop, saturate, volume scale
module audio_dpcm_step
  import audio_pkg::*;
#(
  parameter int SAMPLE_W = 16,
  parameter int DELTA_W  = 12,
  parameter int VOL_W    = 8,
  parameter int POS_W    = 24
) (
  input  logic signed [SAMPLE_W-1:0] last_sample,
  input  logic signed [DELTA_W-1:0]  delta,
  input  logic [POS_W-1:0]           pos,
  input  logic [POS_W-1:0]           sample_count,
  input  logic [POS_W-1:0]           loop_start,
  input  logic [POS_W-1:0]           loop_end,
  input  logic                       looping,
  input  logic signed [SAMPLE_W-1:0] loop_start_sample,
  input  logic [VOL_W-1:0]           volume,
  output logic signed [SAMPLE_W-1:0] sample,
  output logic [POS_W-1:0]           next_pos,
  output logic                       finished,
  output logic signed [SAMPLE_W:0]   scaled
);

  logic signed [SAMPLE_W:0]       delta_x;
  logic signed [SAMPLE_W:0]       sum;
  logic [POS_W:0]                 pos_p1;
  logic                           wrap;
  logic signed [SAMPLE_W+VOL_W:0] prod;

  // pos+1 is kept one bit wider so the end/loop compares cannot wrap
  assign pos_p1   = {1'b0, pos} + {{POS_W{1'b0}}, 1'b1};
  assign wrap     = looping && (pos_p1 >= {1'b0, loop_end});
  assign finished = !looping && (pos_p1 >= {1'b0, sample_count});
  assign next_pos = wrap ? loop_start : pos_p1[POS_W-1:0];

  assign delta_x = {{(SAMPLE_W + 1 - DELTA_W){delta[DELTA_W-1]}}, delta};
  assign sum     = wrap ? {loop_start_sample[SAMPLE_W-1], loop_start_sample}
                        : {last_sample[SAMPLE_W-1], last_sample} + (delta_x <<< 1);
  assign sample  = SAMPLE_W'(sat({{(32 - SAMPLE_W - 1){sum[SAMPLE_W]}}, sum}, SAMPLE_W));

  assign prod   = sample * signed'({1'b0, volume});
  assign scaled = (SAMPLE_W + 1)'(prod >>> VOL_W);

endmodule

// File: rtl/audio_channel_bank.sv
// rtl/audio_channel_bank.sv - time-multiplexed DPCM playback bank with a single fetch port and mixer
module audio_channel_bank
  import audio_pkg::*;
#(
  parameter int NUM_CHANNELS = 8,
  parameter int SAMPLE_W     = 16,
  parameter int DELTA_W      = 12,
  parameter int VOL_W        = 8,
  parameter int POS_W        = 24,
  parameter int ADDR_W       = 32,
  localparam int CH_W        = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       w_valid,
  input  logic [CH_W-1:0]            w_channel,
  input  logic [3:0]                 w_select,
  input  logic [POS_W-1:0]           w_data,
  input  logic                       lrclk,
  output logic                       o_fetch_valid,
  output logic [ADDR_W-1:0]          o_fetch_addr,
  input  logic                       i_fetch_ready,
  input  logic                       i_delta_valid,
  input  logic signed [DELTA_W-1:0]  i_delta,
  output logic signed [SAMPLE_W-1:0] o_mix,
  output logic                       o_mix_valid,
  output logic                       o_busy,
  output logic                       o_overrun
);

  localparam int ACC_W = SAMPLE_W + $clog2(NUM_CHANNELS) + 1;

  logic [POS_W-1:0]           start_r [NUM_CHANNELS];
  logic [POS_W-1:0]           pos_r   [NUM_CHANNELS];
  logic [POS_W-1:0]           count_r [NUM_CHANNELS];
  logic [POS_W-1:0]           lstart_r[NUM_CHANNELS];
  logic [POS_W-1:0]           lend_r  [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] last_r  [NUM_CHANNELS];
  logic signed [SAMPLE_W-1:0] lss_r   [NUM_CHANNELS];
  logic [VOL_W-1:0]           vol_r   [NUM_CHANNELS];
  logic [NUM_CHANNELS-1:0]    playing_r, looping_r, stereo_r, left_r;

  state_e                     state, state_next;
  logic [CH_W-1:0]            ch;
  logic signed [ACC_W-1:0]    acc;
  logic signed [DELTA_W-1:0]  delta_q;
  logic                       lrclk_q;
  logic                       lr_edge;
  logic [ADDR_W-1:0]          addr_calc;
  logic signed [SAMPLE_W-1:0] step_sample;
  logic [POS_W-1:0]           step_pos;
  logic                       step_finished;
  logic signed [SAMPLE_W:0]   step_scaled;

  assign lr_edge       = lrclk && !lrclk_q;
  assign o_busy        = (state != ST_IDLE);
  assign o_fetch_valid = (state == ST_REQ);

  always_comb begin
    addr_calc = ADDR_W'(start_r[ch]);
    if (stereo_r[ch])
      addr_calc = addr_calc + (ADDR_W'(pos_r[ch]) << 1) + (left_r[ch] ? ADDR_W'(2) : ADDR_W'(3));
    else
      addr_calc = addr_calc + ADDR_W'(pos_r[ch]) + ADDR_W'(1);
  end

  audio_dpcm_step #(
    .SAMPLE_W(SAMPLE_W), .DELTA_W(DELTA_W), .VOL_W(VOL_W), .POS_W(POS_W)
  ) u_step (
    .last_sample      (last_r[ch]),
    .delta            (delta_q),
    .pos              (pos_r[ch]),
    .sample_count     (count_r[ch]),
    .loop_start       (lstart_r[ch]),
    .loop_end         (lend_r[ch]),
    .looping          (looping_r[ch]),
    .loop_start_sample(lss_r[ch]),
    .volume           (vol_r[ch]),
    .sample           (step_sample),
    .next_pos         (step_pos),
    .finished         (step_finished),
    .scaled           (step_scaled)
  );

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (lr_edge) state_next = ST_SELECT;
      ST_SELECT: state_next = playing_r[ch] ? ST_REQ : ST_NEXT;
      ST_REQ:    if (i_fetch_ready) state_next = ST_WAIT;
      ST_WAIT:   if (i_delta_valid) state_next = ST_STEP;
      ST_STEP:   state_next = ST_NEXT;
      ST_NEXT:   state_next = (ch == CH_W'(NUM_CHANNELS - 1)) ? ST_DONE : ST_SELECT;
      ST_DONE:   state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      ch           <= '0;
      acc          <= '0;
      delta_q      <= '0;
      lrclk_q      <= 1'b0;
      o_fetch_addr <= '0;
      o_mix        <= '0;
      o_mix_valid  <= 1'b0;
      o_overrun    <= 1'b0;
    end else begin
      state       <= state_next;
      lrclk_q     <= lrclk;
      o_mix_valid <= 1'b0;
      if (state == ST_IDLE && lr_edge) begin
        ch  <= '0;
        acc <= '0;
      end
      if (state == ST_SELECT) o_fetch_addr <= addr_calc;
      if (state == ST_WAIT && i_delta_valid) delta_q <= i_delta;
      if (state == ST_STEP)
        acc <= acc + {{(ACC_W - SAMPLE_W - 1){step_scaled[SAMPLE_W]}}, step_scaled};
      if (state == ST_NEXT && ch != CH_W'(NUM_CHANNELS - 1)) ch <= ch + 1'b1;
      if (state == ST_DONE) begin
        o_mix       <= SAMPLE_W'(sat({{(32 - ACC_W){acc[ACC_W-1]}}, acc}, SAMPLE_W));
        o_mix_valid <= 1'b1;
      end
      if (w_valid && w_select == SET_CLEAR_OVR) o_overrun <= 1'b0;
      if (lr_edge && state != ST_IDLE) o_overrun <= 1'b1;
    end
  end

  // Engine update first, host write after it so the host wins on a collision.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        start_r[i]  <= '0;
        pos_r[i]    <= '0;
        count_r[i]  <= '0;
        lstart_r[i] <= '0;
        lend_r[i]   <= '0;
        last_r[i]   <= '0;
        lss_r[i]    <= '0;
        vol_r[i]    <= '0;
      end
      playing_r <= '0;
      looping_r <= '0;
      stereo_r  <= '0;
      left_r    <= '0;
    end else begin
      if (state == ST_STEP) begin
        pos_r[ch]  <= step_pos;
        last_r[ch] <= step_sample;
        if (step_pos == lstart_r[ch]) lss_r[ch] <= step_sample;
        if (step_finished) playing_r[ch] <= 1'b0;
      end
      if (w_valid) begin
        case (channel_setting_e'(w_select))
          SET_START:           start_r[w_channel]   <= w_data;
          SET_POSITION:        pos_r[w_channel]     <= w_data;
          SET_SAMPLECOUNT:     count_r[w_channel]   <= w_data;
          SET_LOOPSTART:       lstart_r[w_channel]  <= w_data;
          SET_LOOPEND:         lend_r[w_channel]    <= w_data;
          SET_ISLOOPING:       looping_r[w_channel] <= w_data[0];
          SET_ISPLAYING:       playing_r[w_channel] <= w_data[0];
          SET_VOLUME:          vol_r[w_channel]     <= w_data[VOL_W-1:0];
          SET_LASTSAMPLE:      last_r[w_channel]    <= w_data[SAMPLE_W-1:0];
          SET_ISSTEREO:        stereo_r[w_channel]  <= w_data[0];
          SET_ISLEFT:          left_r[w_channel]    <= w_data[0];
          SET_LOOPSTARTSAMPLE: lss_r[w_channel]     <= w_data[SAMPLE_W-1:0];
          default: ;
        endcase
      end
    end
  end

endmodule
